// File: rtl/mem_arbiter.sv
// Two-requester shared-memory arbiter: an instruction-fetch port and a data port
// share one handshake memory bus, with round-robin tie-break and an ack timeout.
module mem_arbiter #(
  parameter logic [7:0]  TIMEOUT  = 8'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,

  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,

  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,

  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        gnt;        // current owner: 0 = IF, 1 = D
  logic        lg;         // owner of the last completed transfer
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;

  logic        if_want;
  logic        d_want;
  logic        any_want;
  logic        grant_d;
  logic        timeout_hit;
  logic        rsp_load;
  logic [31:0] rsp_data;

  // Arbitration: a lone requester wins; on a tie the side not served last wins.
  assign if_want  = if_req;
  assign d_want   = d_read | d_write;
  assign any_want = if_want | d_want;
  assign grant_d  = d_want & (~if_want | ~lg);

  // An ack in the same cycle the counter would reach TIMEOUT still counts as success.
  assign cnt_inc     = cnt + 8'd1;
  assign timeout_hit = ~m_ack & (cnt_inc == TIMEOUT);
  assign rsp_load    = (state == S_WAIT) & (m_ack | timeout_hit);
  assign rsp_data    = m_ack ? m_rdata : ERR_DATA;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first so every path drives state_next and no latch
  // is inferred from an incomplete case.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (any_want)              state_next = S_WAIT;
      S_WAIT: if (m_ack || timeout_hit)  state_next = S_RESP;
      S_RESP:                            state_next = S_IDLE;
      default:                           state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs are decoded from state, so an asynchronous
  // reset drops them immediately together with the state register.
  always_comb begin
    busy     = 1'b0;
    m_req    = 1'b0;
    if_valid = 1'b0;
    d_done   = 1'b0;
    case (state)
      S_IDLE: ;
      S_WAIT: begin
        busy  = 1'b1;
        m_req = 1'b1;
      end
      S_RESP: begin
        busy     = 1'b1;
        if_valid = ~gnt;
        d_done   = gnt;
      end
      default: ;
    endcase
  end

  // Grant, request payload and timeout counter; payload holds steady through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt     <= 1'b0;
      lg      <= 1'b0;
      cnt     <= 8'd0;
      m_we    <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_want) begin
            gnt     <= grant_d;
            cnt     <= 8'd0;
            m_we    <= grant_d & d_write;
            m_addr  <= grant_d ? d_addr  : if_addr;
            m_wdata <= grant_d ? d_wdata : 32'd0;
          end
        end
        S_WAIT: begin
          if (!m_ack && !timeout_hit) begin
            cnt <= cnt_inc;
          end
        end
        S_RESP: begin
          lg <= gnt;
        end
        default: ;
      endcase
    end
  end

  // Response data registers hold between pulses; a write never touches d_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
      err      <= 1'b0;
    end else begin
      if (rsp_load) begin
        if (!gnt) begin
          if_rdata <= rsp_data;
        end else if (!m_we) begin
          d_rdata <= rsp_data;
        end
      end
      if ((state == S_WAIT) && timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, round-robin
// contention, read+write collision, ack-at-limit, timeout and mid-transfer reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ifv    = 0;
  int n_dd     = 0;

  mem_arbiter #(
    .TIMEOUT  (8'd4),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (if_valid === 1'b1) n_ifv = n_ifv + 1;
    if (d_done   === 1'b1) n_dd  = n_dd + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int ifv_base;
    int dd_base;
    logic        exp_owner [4];
    logic [31:0] rd;

    exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; if_req = 1'b0; if_addr = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    m_rdata = 32'd0; m_ack = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_m_req",    32'(m_req),    32'd0);
    check("rst_m_we",     32'(m_we),     32'd0);
    check("rst_m_addr",   m_addr,        32'd0);
    check("rst_m_wdata",  m_wdata,       32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_rdata", if_rdata,      32'd0);
    check("rst_d_done",   32'(d_done),   32'd0);
    check("rst_d_rdata",  d_rdata,       32'd0);
    check("rst_err",      32'(err),      32'd0);
    rst = 1'b1;

    // Single fetch, ack sampled on the third edge after grant
    ifv_base = n_ifv; dd_base = n_dd;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    tick();
    check("fetch_m_req",  32'(m_req), 32'd1);
    check("fetch_m_addr", m_addr,     32'h0000_0100);
    check("fetch_m_we",   32'(m_we),  32'd0);
    check("fetch_busy",   32'(busy),  32'd1);
    if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    tick(); tick();
    check("fetch_hold_req",  32'(m_req), 32'd1);
    check("fetch_hold_addr", m_addr,     32'h0000_0100);
    m_ack = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    m_ack = 1'b0; m_rdata = 32'h1111_1111;
    check("fetch_valid",  32'(if_valid), 32'd1);
    check("fetch_rdata",  if_rdata,      32'h0050_0093);
    check("fetch_req_dn", 32'(m_req),    32'd0);
    tick();
    check("fetch_valid_dn", 32'(if_valid), 32'd0);
    check("fetch_rdata_hd", if_rdata,      32'h0050_0093);
    check("fetch_idle",     32'(busy),     32'd0);
    check("fetch_nvalid",   32'(n_ifv - ifv_base), 32'd1);
    check("fetch_no_ddone", 32'(n_dd - dd_base),   32'd0);

    // Store with immediate ack
    d_write = 1'b1; d_addr = 32'h0000_9000; d_wdata = 32'hA5A5_A5A5;
    tick();
    check("store_m_we",    32'(m_we),   32'd1);
    check("store_m_addr",  m_addr,      32'h0000_9000);
    check("store_m_wdata", m_wdata,     32'hA5A5_A5A5);
    check("store_done_e",  32'(d_done), 32'd0);
    d_write = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    m_ack = 1'b0;
    check("store_done",  32'(d_done), 32'd1);
    check("store_rdata", d_rdata,     32'd0);
    tick();
    check("store_done_dn", 32'(d_done), 32'd0);

    // Contention from reset: D, IF, D, IF
    rst = 1'b0; tick(); rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_read = 1'b1; d_addr  = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("cont%0d_addr", k), m_addr,
            exp_owner[k] ? 32'h0000_0300 : 32'h0000_0200);
      m_ack = 1'b1; m_rdata = 32'hC0DE_0000 + 32'(k);
      tick();
      m_ack = 1'b0;
      check($sformatf("cont%0d_ddone", k), 32'(d_done),   32'(exp_owner[k]));
      check($sformatf("cont%0d_ifval", k), 32'(if_valid), 32'(!exp_owner[k]));
      rd = exp_owner[k] ? d_rdata : if_rdata;
      check($sformatf("cont%0d_data", k), rd, 32'hC0DE_0000 + 32'(k));
      tick();
      check($sformatf("cont%0d_idle", k), 32'(busy), 32'd0);
    end
    if_req = 1'b0; d_read = 1'b0;

    // d_read and d_write together act as a write
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h1111_2222;
    tick();
    check("rw_m_we",    32'(m_we), 32'd1);
    check("rw_m_wdata", m_wdata,   32'h1111_2222);
    d_read = 1'b0; d_write = 1'b0; m_ack = 1'b1; m_rdata = 32'h9999_9999;
    tick();
    m_ack = 1'b0;
    check("rw_done",  32'(d_done), 32'd1);
    check("rw_rdata", d_rdata,     32'hC0DE_0002);
    tick();

    // Ack arriving in the cycle the counter reaches TIMEOUT is a success
    if_req = 1'b1; if_addr = 32'h0000_0500;
    tick();
    if_req = 1'b0;
    tick(); tick(); tick();
    check("edge_req_held", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    tick();
    m_ack = 1'b0;
    check("edge_valid", 32'(if_valid), 32'd1);
    check("edge_rdata", if_rdata,      32'h0BAD_F00D);
    check("edge_err",   32'(err),      32'd0);
    tick();

    // Timeout: no ack, m_req drops after 4 WAIT cycles
    d_read = 1'b1; d_addr = 32'h0000_0600;
    tick();
    d_read = 1'b0;
    tick(); tick(); tick();
    check("to_req_held", 32'(m_req), 32'd1);
    check("to_err_pre",  32'(err),   32'd0);
    tick();
    check("to_req_dn", 32'(m_req),  32'd0);
    check("to_done",   32'(d_done), 32'd1);
    check("to_rdata",  d_rdata,     32'hDEAD_BEEF);
    check("to_err",    32'(err),    32'd1);
    tick();
    check("to_idle", 32'(busy), 32'd0);

    // Stray ack in IDLE is ignored; err stays sticky
    dd_base = n_dd; ifv_base = n_ifv;
    m_ack = 1'b1; m_rdata = 32'h7777_7777;
    tick();
    m_ack = 1'b0;
    tick();
    check("stray_busy",  32'(busy), 32'd0);
    check("stray_pulse", 32'((n_dd - dd_base) + (n_ifv - ifv_base)), 32'd0);
    check("stray_err",   32'(err),  32'd1);

    // Reset one cycle after m_req rises
    if_req = 1'b1; if_addr = 32'h0000_0700;
    tick();
    if_req = 1'b0;
    check("mid_req_up", 32'(m_req), 32'd1);
    dd_base = n_dd; ifv_base = n_ifv;
    tick();
    #2 rst = 1'b0;
    #1;
    check("mid_req_dn", 32'(m_req), 32'd0);
    check("mid_busy",   32'(busy),  32'd0);
    check("mid_err",    32'(err),   32'd0);
    tick(); tick();
    rst = 1'b1;
    check("mid_no_pulse", 32'((n_dd - dd_base) + (n_ifv - ifv_base)), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0800;
    tick();
    if_req = 1'b0;
    check("post_m_addr", m_addr, 32'h0000_0800);
    m_ack = 1'b1; m_rdata = 32'hFEED_FACE;
    tick();
    m_ack = 1'b0;
    check("post_valid", 32'(if_valid), 32'd1);
    check("post_rdata", if_rdata,      32'hFEED_FACE);
    tick();
    check("post_pulses", 32'(n_ifv - ifv_base), 32'd1);
    check("post_ddone",  32'(n_dd - dd_base),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
